// File: rtl/ram_arbiter_2p_pkg.sv
// Shared definitions for the two-port RAM arbiter: lock-owner encoding and
// the sizing rule for the burst counter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    // The counter must be able to hold the value MAX_BURST itself
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_2p_rr_lock_arb.sv
// Round-robin grant logic with optional per-port burst lock and a burst
// limit that forces a handoff when the other port keeps requesting.
module rr_lock_arb #(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);
    import ram_arb_pkg::*;

    localparam int            CW      = burst_cnt_width(MAX_BURST);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    logic          last_winner_q, last_winner_d;
    owner_e        lock_owner_q, lock_owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          req0_v, req1_v;
    owner_e        win_own;
    logic          win_lock;
    logic          other_req;

    // Grant decision: single requester wins, else honour a live lock, else alternate
    always_comb begin
        req0_v = req0 & rst_n;
        req1_v = req1 & rst_n;
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (req0_v && !req1_v) begin
            gnt0 = 1'b1;
        end else if (req1_v && !req0_v) begin
            gnt1 = 1'b1;
        end else if (req0_v && req1_v) begin
            if (lock_owner_q == OWN_P0 && burst_cnt_q < MAX_CNT) begin
                gnt0 = 1'b1;
            end else if (lock_owner_q == OWN_P1 && burst_cnt_q < MAX_CNT) begin
                gnt1 = 1'b1;
            end else if (last_winner_q) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end
    end

    // Next state for round-robin pointer, lock owner and burst length
    always_comb begin
        last_winner_d = last_winner_q;
        lock_owner_d  = lock_owner_q;
        burst_cnt_d   = burst_cnt_q;
        win_own       = gnt1 ? OWN_P1 : OWN_P0;
        win_lock      = gnt1 ? lock1 : lock0;
        other_req     = gnt1 ? req0_v : req1_v;
        if (gnt0 || gnt1) begin
            last_winner_d = gnt1;
            if (!win_lock) begin
                lock_owner_d = OWN_NONE;
                burst_cnt_d  = '0;
            end else if (lock_owner_q == win_own) begin
                lock_owner_d = win_own;
                if (other_req) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end else begin
                lock_owner_d = win_own;
                burst_cnt_d  = CW'(1);
            end
            if (lock_owner_d != OWN_NONE && burst_cnt_d >= MAX_CNT) begin
                lock_owner_d = OWN_NONE;
                burst_cnt_d  = '0;
            end
        end else begin
            lock_owner_d = OWN_NONE;
            burst_cnt_d  = '0;
        end
    end

    // Arbitration state register; port0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner_q <= 1'b1;
            lock_owner_q  <= OWN_NONE;
            burst_cnt_q   <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            lock_owner_q  <= lock_owner_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Two-master front end for a single-port synchronous RAM: command mux with
// zero added latency and a one-cycle read-valid pipeline per port.
module ram_arbiter_2p #(
    parameter int AW        = 13,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            REQ0,
    input  logic            REQ1,
    input  logic            LOCK0,
    input  logic            LOCK1,
    input  logic [DW/8-1:0] WE0,
    input  logic [DW/8-1:0] WE1,
    input  logic [AW-1:0]   A0,
    input  logic [AW-1:0]   A1,
    input  logic [DW-1:0]   Di0,
    input  logic [DW-1:0]   Di1,
    output logic            ACK0,
    output logic            ACK1,
    output logic            RVALID0,
    output logic            RVALID1,
    output logic [DW-1:0]   Do,
    output logic            RAM_EN,
    output logic [DW/8-1:0] RAM_WE,
    output logic [AW-1:0]   RAM_A,
    output logic [DW-1:0]   RAM_Di,
    input  logic [DW-1:0]   RAM_Do
);
    import ram_arb_pkg::*;

    logic          gnt0, gnt1;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [DW-1:0] ram_di_q, ram_di_d;
    logic          rd_pend0_q, rd_pend0_d;
    logic          rd_pend1_q, rd_pend1_d;

    rr_lock_arb #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk  (CLK),
        .rst_n(RSTn),
        .req0 (REQ0),
        .req1 (REQ1),
        .lock0(LOCK0),
        .lock1(LOCK1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Route the winner's command to the RAM; address and data hold when idle
    always_comb begin
        RAM_EN = 1'b0;
        RAM_WE = '0;
        RAM_A  = ram_a_q;
        RAM_Di = ram_di_q;
        if (gnt0) begin
            RAM_EN = 1'b1;
            RAM_WE = WE0;
            RAM_A  = A0;
            RAM_Di = Di0;
        end else if (gnt1) begin
            RAM_EN = 1'b1;
            RAM_WE = WE1;
            RAM_A  = A1;
            RAM_Di = Di1;
        end
    end

    // Capture the driven command fields and flag granted reads for return
    always_comb begin
        ram_a_d    = RAM_A;
        ram_di_d   = RAM_Di;
        rd_pend0_d = gnt0 && (WE0 == '0);
        rd_pend1_d = gnt1 && (WE1 == '0);
    end

    // Held command fields and read-valid flags; reset discards pending reads
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ram_a_q    <= '0;
            ram_di_q   <= '0;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
        end else begin
            ram_a_q    <= ram_a_d;
            ram_di_q   <= ram_di_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
        end
    end

    assign ACK0    = gnt0;
    assign ACK1    = gnt1;
    assign RVALID0 = rd_pend0_q;
    assign RVALID1 = rd_pend1_q;
    assign Do      = RAM_Do;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: RAM macro model, behavioural reference with
// per-cycle comparison, directed scenarios and a randomized run.
module tb_ram_arbiter_2p;
    localparam int AW        = 13;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic        req;
        logic        lock;
        logic [3:0]  we;
        logic [12:0] a;
        logic [31:0] d;
    } cmd_t;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        REQ0 = 0, REQ1 = 0, LOCK0 = 0, LOCK1 = 0;
    logic [3:0]  WE0 = 0, WE1 = 0;
    logic [12:0] A0 = 0, A1 = 0;
    logic [31:0] Di0 = 0, Di1 = 0;
    logic        ACK0, ACK1, RVALID0, RVALID1, RAM_EN;
    logic [31:0] Do, RAM_Di;
    logic [31:0] RAM_Do = 0;
    logic [3:0]  RAM_WE;
    logic [12:0] RAM_A;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram_arbiter_2p #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .REQ0(REQ0), .REQ1(REQ1), .LOCK0(LOCK0), .LOCK1(LOCK1),
        .WE0(WE0), .WE1(WE1), .A0(A0), .A1(A1), .Di0(Di0), .Di1(Di1),
        .ACK0(ACK0), .ACK1(ACK1), .RVALID0(RVALID0), .RVALID1(RVALID1), .Do(Do),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_Di(RAM_Di),
        .RAM_Do(RAM_Do)
    );

    // Single-port RAM macro with one-cycle synchronous read
    logic [31:0] ram [0:8191];
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE == 4'h0) RAM_Do <= ram[RAM_A];
            for (int b = 0; b < 4; b++)
                if (RAM_WE[b]) ram[RAM_A][8*b +: 8] <= RAM_Di[8*b +: 8];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: memory image, who owns a burst, how long it has run
    logic [31:0] ref_mem [0:8191];
    int          m_last, m_lock, m_cnt;
    logic [12:0] m_a;
    logic [31:0] m_di;
    bit          exp_rv0, exp_rv1;
    logic [31:0] exp_do;
    int          grant_log[$];
    int          g;
    logic [3:0]  e_we;
    logic [12:0] e_a;
    logic [31:0] e_di;
    bit          other, lk;

    // Mid-cycle comparison of every DUT output against the model
    always @(negedge CLK) begin
        if (!RSTn) begin
            m_last = 1; m_lock = -1; m_cnt = 0; m_a = '0; m_di = '0;
            exp_rv0 = 0; exp_rv1 = 0;
            checkOutput("rst_ack0", 32'(ACK0), 0);
            checkOutput("rst_ack1", 32'(ACK1), 0);
            checkOutput("rst_rvalid0", 32'(RVALID0), 0);
            checkOutput("rst_rvalid1", 32'(RVALID1), 0);
            checkOutput("rst_ram_en", 32'(RAM_EN), 0);
            checkOutput("rst_ram_we", 32'(RAM_WE), 0);
            checkOutput("rst_ram_a", 32'(RAM_A), 0);
            checkOutput("rst_ram_di", RAM_Di, 0);
        end else begin
            g = -1;
            if (REQ0 && !REQ1) g = 0;
            else if (REQ1 && !REQ0) g = 1;
            else if (REQ0 && REQ1) g = (m_lock >= 0 && m_cnt < MAX_BURST) ? m_lock : 1 - m_last;
            e_we = (g == 0) ? WE0 : (g == 1) ? WE1 : 4'h0;
            e_a  = (g == 0) ? A0  : (g == 1) ? A1  : m_a;
            e_di = (g == 0) ? Di0 : (g == 1) ? Di1 : m_di;
            checkOutput("ack0", 32'(ACK0), 32'(g == 0));
            checkOutput("ack1", 32'(ACK1), 32'(g == 1));
            checkOutput("ram_en", 32'(RAM_EN), 32'(g >= 0));
            checkOutput("ram_we", 32'(RAM_WE), 32'(e_we));
            checkOutput("ram_a", 32'(RAM_A), 32'(e_a));
            checkOutput("ram_di", RAM_Di, e_di);
            checkOutput("rvalid0", 32'(RVALID0), 32'(exp_rv0));
            checkOutput("rvalid1", 32'(RVALID1), 32'(exp_rv1));
            if (exp_rv0 || exp_rv1) checkOutput("do", Do, exp_do);
            exp_rv0 = 0; exp_rv1 = 0;
            if (g >= 0) begin
                m_a = e_a; m_di = e_di;
                if (e_we == 4'h0) begin
                    exp_do = ref_mem[e_a];
                    if (g == 0) exp_rv0 = 1; else exp_rv1 = 1;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (e_we[b]) ref_mem[e_a][8*b +: 8] = e_di[8*b +: 8];
                end
                other = (g == 0) ? REQ1 : REQ0;
                lk    = (g == 0) ? LOCK0 : LOCK1;
                if (!lk) begin
                    m_lock = -1; m_cnt = 0;
                end else if (m_lock == g) begin
                    if (other) m_cnt = m_cnt + 1;
                end else begin
                    m_lock = g; m_cnt = 1;
                end
                if (m_lock >= 0 && m_cnt >= MAX_BURST) begin
                    m_lock = -1; m_cnt = 0;
                end
                m_last = g;
            end else begin
                m_lock = -1; m_cnt = 0;
            end
            grant_log.push_back(g);
        end
    end

    function automatic cmd_t mk(input bit req, input bit lock, input logic [3:0] we,
                                input logic [12:0] a, input logic [31:0] d);
        cmd_t c;
        c.req = req; c.lock = lock; c.we = we; c.a = a; c.d = d;
        return c;
    endfunction

    // Drive one cycle of commands just after the edge, return mid-cycle
    task automatic applyStimulus(input cmd_t c0, input cmd_t c1);
        @(posedge CLK); #1;
        REQ0 = c0.req; LOCK0 = c0.lock; WE0 = c0.we; A0 = c0.a; Di0 = c0.d;
        REQ1 = c1.req; LOCK1 = c1.lock; WE1 = c1.we; A1 = c1.a; Di1 = c1.d;
        @(negedge CLK); #1;
    endtask

    task automatic clearInputs();
        REQ0 = 0; LOCK0 = 0; WE0 = 0; A0 = 0; Di0 = 0;
        REQ1 = 0; LOCK1 = 0; WE1 = 0; A1 = 0; Di1 = 0;
    endtask

    task automatic applyReset();
        @(posedge CLK); #1;
        RSTn = 0;
        clearInputs();
        repeat (2) @(negedge CLK);
        #1;
        RSTn = 1;
    endtask

    function automatic int dutGrant();
        return ACK1 ? 1 : (ACK0 ? 0 : -1);
    endfunction

    cmd_t idle, c0, c1;
    int   exp_rr[6]  = '{0, 1, 0, 1, 0, 1};
    int   exp_lk[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    int   wait_n;
    bit   p0_hold, p1_hold;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        idle = mk(0, 0, 4'h0, 13'h0, 32'h0);

        // Full write then read-back on port0
        applyReset();
        applyStimulus(mk(1, 0, 4'hF, 13'h0010, 32'hDEADBEEF), idle);
        checkOutput("wr_ack0", 32'(ACK0), 1);
        checkOutput("wr_ram_en", 32'(RAM_EN), 1);
        checkOutput("wr_ram_a", 32'(RAM_A), 32'h0010);
        applyStimulus(mk(1, 0, 4'h0, 13'h0010, 32'h0), idle);
        checkOutput("rd_ack0", 32'(ACK0), 1);
        applyStimulus(idle, idle);
        checkOutput("rd_rvalid0", 32'(RVALID0), 1);
        checkOutput("rd_do", Do, 32'hDEADBEEF);

        // Plain contention alternates, port0 first
        applyReset();
        grant_log.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(mk(1, 0, 4'h0, 13'(i), 32'h0), mk(1, 0, 4'h0, 13'(i + 8), 32'h0));
            checkOutput("rr_dut_grant", 32'(dutGrant()), 32'(exp_rr[i]));
        end
        for (int i = 0; i < 6; i++) checkOutput("rr_model_grant", 32'(grant_log[i]), 32'(exp_rr[i]));

        // Locked burst on port0 is cut after MAX_BURST grants
        applyReset();
        grant_log.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(mk(1, 1, 4'h0, 13'h20, 32'h0), mk(1, 0, 4'h0, 13'h21, 32'h0));
            checkOutput("lock_dut_grant", 32'(dutGrant()), 32'(exp_lk[i]));
        end
        for (int i = 0; i < 8; i++) checkOutput("lock_model_grant", 32'(grant_log[i]), 32'(exp_lk[i]));

        // Partial-byte write on port1 at the top address
        applyStimulus(idle, mk(1, 0, 4'hF, 13'h1FFF, 32'h11223344));
        applyStimulus(idle, mk(1, 0, 4'b0010, 13'h1FFF, 32'h0000AB00));
        checkOutput("bw_ram_we", 32'(RAM_WE), 32'h2);
        applyStimulus(idle, mk(1, 0, 4'h0, 13'h1FFF, 32'h0));
        applyStimulus(idle, idle);
        checkOutput("bw_rvalid1", 32'(RVALID1), 1);
        checkOutput("bw_rvalid0", 32'(RVALID0), 0);
        checkOutput("bw_do", Do, 32'h1122AB44);

        // Reset lands between a read grant and its return
        applyStimulus(mk(1, 0, 4'h0, 13'h0010, 32'h0), idle);
        checkOutput("mr_ack0", 32'(ACK0), 1);
        #2 RSTn = 0;
        @(negedge CLK); #1;
        checkOutput("mr_rvalid0", 32'(RVALID0), 0);
        checkOutput("mr_ack0_rst", 32'(ACK0), 0);
        checkOutput("mr_ram_en", 32'(RAM_EN), 0);
        @(negedge CLK); #1;
        clearInputs();
        RSTn = 1;
        applyStimulus(mk(1, 0, 4'h0, 13'h1, 32'h0), mk(1, 0, 4'h0, 13'h2, 32'h0));
        checkOutput("mr_first_tie", 32'(dutGrant()), 0);

        // Lone locked requester keeps the RAM, then yields within the burst limit
        applyReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(idle, mk(1, 1, 4'h0, 13'h30, 32'h0));
            checkOutput("solo_ack1", 32'(ACK1), 1);
        end
        wait_n = 0;
        for (int i = 1; i <= MAX_BURST + 2 && wait_n == 0; i++) begin
            applyStimulus(mk(1, 0, 4'h0, 13'h31, 32'h0), mk(1, 1, 4'h0, 13'h30, 32'h0));
            if (ACK0) wait_n = i;
        end
        checkOutput("handoff_wait", 32'(wait_n), 32'(MAX_BURST));

        // Randomized traffic; a requester holds its command until accepted
        applyReset();
        p0_hold = 0; p1_hold = 0;
        c0 = idle; c1 = idle;
        for (int n = 0; n < 2000; n++) begin
            if (!p0_hold) begin
                c0.req = ($urandom_range(0, 3) != 0);
                c0.we  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                c0.a   = 13'($urandom_range(0, 15));
                c0.d   = $urandom;
            end
            if (!p1_hold) begin
                c1.req = ($urandom_range(0, 3) != 0);
                c1.we  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                c1.a   = 13'($urandom_range(0, 15));
                c1.d   = $urandom;
            end
            c0.lock = 1'($urandom_range(0, 1));
            c1.lock = 1'($urandom_range(0, 1));
            applyStimulus(c0, c1);
            p0_hold = c0.req && !ACK0;
            p1_hold = c1.req && !ACK1;
        end
        applyStimulus(idle, idle);
        applyStimulus(idle, idle);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
